// File: rtl/shift_reg_sequencer.sv
// Sequencer that drives the control/data pins of a universal shift register
// through PIPO, SIPO, SISO and PISO transfers using a three-state FSM.
module shift_reg_sequencer #(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_mode,
  input  logic          req_dir,
  input  logic [DW-1:0] req_data,
  input  logic          abort,
  output logic          reg_enb,
  output logic          reg_l_s,
  output logic          reg_left_right,
  output logic [2:0]    reg_selector,
  output logic [DW-1:0] reg_inp,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = $clog2(DW + 1);

  localparam logic [1:0] ModePipo = 2'd0;
  localparam logic [1:0] ModeSipo = 2'd1;
  localparam logic [1:0] ModeSiso = 2'd2;
  localparam logic [1:0] ModePiso = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic            dir_q, dir_d;
  logic [DW-1:0]   data_q, data_d;

  logic            accept;
  logic            last_beat;
  logic [CW-1:0]   last_idx;
  logic [DW-1:0]   data_shr;
  logic [DW-1:0]   data_shl;
  logic            serial_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    accept    = (state_q == StIdle) && req_valid;
    last_idx  = (mode_q == ModePipo) ? '0 : CW'(DW - 1);
    last_beat = (cnt_q == last_idx);

    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    data_d  = data_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          cnt_d   = '0;
          mode_d  = req_mode;
          dir_d   = req_dir;
          data_d  = req_data;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CW'(1);
        // Abort takes priority over completing the final beat.
        if (abort) begin
          state_d = StIdle;
        end else if (last_beat) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Serial bit for beat k: MSB-first (bit DW-1-k) for left, LSB-first (bit k) for right.
  always_comb begin
    data_shr   = data_q >> cnt_q;
    data_shl   = data_q << cnt_q;
    serial_bit = dir_q ? data_shr[0] : data_shl[DW-1];
  end

  always_comb begin
    req_ready      = (state_q == StIdle);
    busy           = (state_q == StRun) || (state_q == StDone);
    done           = (state_q == StDone);
    reg_enb        = (state_q == StRun);
    reg_l_s        = 1'b0;
    reg_left_right = dir_q;
    reg_selector   = {1'b0, mode_q};
    reg_inp        = '0;

    if (state_q == StRun) begin
      unique case (mode_q)
        ModePipo: reg_inp = data_q;
        ModeSipo,
        ModeSiso: reg_inp[DW-1] = serial_bit;
        ModePiso: begin
          if (cnt_q == '0) begin
            reg_inp = data_q;
            reg_l_s = 1'b1;
          end
        end
        default: reg_inp = '0;
      endcase
    end
  end

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 The block SHALL have parameter `DW`, default 4: data width of the controlled universal register (DW >= 2).
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port `req_valid`, input, 1 bit: a transfer request is present.
REQ-005 The block SHALL have port `req_ready`, output, 1 bit: the sequencer accepts a request this cycle.
REQ-006 The block SHALL have port `req_mode`, input, 2 bits: 0=PIPO, 1=SIPO, 2=SISO, 3=PISO.
REQ-007 The block SHALL have port `req_dir`, input, 1 bit: 0=left shift, 1=right shift.
REQ-008 The block SHALL have port `req_data`, input, DW bits: the word to transfer.
REQ-009 The block SHALL have port `abort`, input, 1 bit: synchronous cancel of the transfer in progress.
REQ-010 The block SHALL have port `reg_enb`, output, 1 bit: drives the register enable.
REQ-011 The block SHALL have port `reg_l_s`, output, 1 bit: drives the register load/shift (1=load).
REQ-012 The block SHALL have port `reg_left_right`, output, 1 bit: drives the register shift direction.
REQ-013 The block SHALL have port `reg_selector`, output, 3 bits: drives the register mode select.
REQ-014 The block SHALL have port `reg_inp`, output, DW bits: drives the register data input.
REQ-015 The block SHALL have port `busy`, output, 1 bit: high while the FSM is in RUN or DONE.
REQ-016 The block SHALL have port `done`, output, 1 bit: one-cycle pulse when a transfer completes.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE: IDLE->RUN on accept; RUN->DONE when the beat counter reaches the last beat; DONE->IDLE after one cycle; RUN->IDLE on abort.
REQ-018 `req_ready` SHALL be 1 only in IDLE; a request is accepted when `req_valid` and `req_ready` are both 1, and `req_mode`, `req_dir` and `req_data` are captured on that edge.
REQ-019 `req_valid` SHALL be ignored while `busy` is 1 (no queuing), and a request held through DONE SHALL be accepted in the following IDLE cycle.
REQ-020 Beat count SHALL be 1 for PIPO and DW for SIPO, SISO and PISO; the beat counter SHALL be $clog2(DW+1) bits wide, clear on accept, and increment once per RUN cycle.
REQ-021 In RUN, `reg_enb` SHALL be 1; in IDLE and DONE, `reg_enb` SHALL be 0.
REQ-022 In PIPO, `reg_inp` SHALL equal the captured data during the single RUN beat.
REQ-023 In SIPO and SISO, beat k SHALL place one serial bit on `reg_inp[DW-1]` with all other bits 0: bit DW-1-k for left, bit k for right.
REQ-024 In PISO, `reg_inp` SHALL equal the captured data and `reg_l_s` SHALL be 1 on beat 0 only; `reg_l_s` SHALL be 0 on beats 1..DW-1 and in all other modes and states.
REQ-025 `reg_selector` SHALL equal {1'b0, captured mode}, and `reg_left_right` SHALL equal the captured direction, from the accept edge until the next accept, so both hold through DONE and IDLE.
REQ-026 `done` SHALL be 1 exactly in the DONE cycle; total latency from the accept edge to `done` SHALL be beats+1 cycles.
REQ-027 `abort` in RUN SHALL return the FSM to IDLE on the next edge with no `done` pulse and `reg_enb` 0 from then on; `abort` in IDLE or DONE SHALL be ignored.
REQ-028 When `abort` and the last beat occur in the same cycle, `abort` SHALL win.
REQ-029 `reg_inp` SHALL be 0 in IDLE and DONE.

Reset
REQ-030 While `rst` = 0, the block SHALL immediately, independent of `clk`, set: state IDLE, counter 0, captured registers 0, `req_ready` 1, `busy` 0, `done` 0, `reg_enb` 0, `reg_l_s` 0, `reg_left_right` 0, `reg_selector` 0, `reg_inp` 0.
REQ-031 Reset asserted mid-transfer SHALL cancel the transfer with no `done` pulse; the first edge after release SHALL be able to accept a request.

Verification (DW=4)
REQ-032 Scenario PIPO: mode 0, data 4'b1001 -> one RUN cycle with `reg_inp`=1001, `reg_enb`=1, `reg_selector`=0; `done` 2 cycles after accept.
REQ-033 Scenario SISO left: mode 2, dir 0, data 4'b1011 -> `reg_inp[3]` sequence 1,0,1,1 over 4 beats, `reg_selector`=2; `done` on cycle 5.
REQ-034 Scenario SIPO right: mode 1, dir 1, data 4'b0001 -> `reg_inp[3]` sequence 1,0,0,0, `reg_left_right`=1 throughout.
REQ-035 Scenario PISO: mode 3, data 4'b0011 -> `reg_l_s`=1 on beat 0 only with `reg_inp`=0011, then 3 shift beats; `done` on cycle 5.
REQ-036 Scenario abort/back-to-back: `abort` on beat 2 of SISO -> IDLE, no `done`; `req_valid` held high -> next request accepted immediately after DONE/IDLE and `req_ready` 0 while busy.
REQ-037 Scenario reset mid-transfer: `rst`=0 during beat 1 of PISO -> all outputs at reset values asynchronously; a request after release completes normally.
